// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if: core data-memory port plus loader write stream
interface data_ram_resp_if #(parameter int DEPTH_LOG2 = 10);
  logic                  ram_we_i;
  logic [3:0]            ram_sel_i;
  logic [DEPTH_LOG2+1:0] ram_addr_i;
  logic [31:0]           ram_data_i;
  logic [31:0]           ram_data_o;
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic [DEPTH_LOG2-1:0] ld_addr_i;
  logic [31:0]           ld_data_i;
  modport master (
    output ram_we_i, ram_sel_i, ram_addr_i, ram_data_i, ld_valid_i, ld_addr_i, ld_data_i,
    input  ram_data_o, ld_ready_o
  );
  modport slave (
    input  ram_we_i, ram_sel_i, ram_addr_i, ram_data_i, ld_valid_i, ld_addr_i, ld_data_i,
    output ram_data_o, ld_ready_o
  );
endinterface

// File: rtl/data_ram_resp.sv
// data_ram_resp: word data RAM with mtime/mtimecmp/gpio MMIO window and loader write port
module data_ram_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int GPIO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_resp_if.slave    bus,
  output logic              timer_irq_o,
  output logic [GPIO_W-1:0] gpio_o
);
  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0]           mem [DEPTH];
  logic [63:0]           mtime;
  logic [31:0]           mtimecmp;
  logic [DEPTH_LOG2-1:0] word;
  logic [1:0]            off;
  logic                  mmio;
  logic [31:0]           lane_mask;
  logic [31:0]           mmio_rd;
  logic                  core_wr;
  logic                  cmp_wr;
  logic                  gpio_wr;
  logic                  irq_hit;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [3:0]            mem_sel;
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, bus.ram_addr_i[1:0]};
  assign word      = bus.ram_addr_i[AW-1:2];
  assign off       = bus.ram_addr_i[3:2];
  assign mmio      = &bus.ram_addr_i[AW-1:4];
  assign lane_mask = {{8{bus.ram_sel_i[3]}}, {8{bus.ram_sel_i[2]}},
                      {8{bus.ram_sel_i[1]}}, {8{bus.ram_sel_i[0]}}};
  assign core_wr   = bus.ram_we_i & ~rst;
  assign cmp_wr    = core_wr & mmio & (off == 2'd2) & |bus.ram_sel_i;
  assign gpio_wr   = core_wr & mmio & (off == 2'd3);
  assign irq_hit   = (mtime[31:0] == mtimecmp) & |mtimecmp;
  assign bus.ld_ready_o = ~bus.ram_we_i;
  // Core and loader share one write port; core always wins the slot.
  assign mem_we   = ~rst & (bus.ram_we_i ? ~mmio : bus.ld_valid_i);
  assign mem_addr = bus.ram_we_i ? word : bus.ld_addr_i;
  assign mem_din  = bus.ram_we_i ? bus.ram_data_i : bus.ld_data_i;
  assign mem_sel  = bus.ram_we_i ? bus.ram_sel_i : 4'hF;
  always_comb
    mmio_rd = off == 2'd0 ? mtime[31:0] :
              off == 2'd1 ? mtime[63:32] :
              off == 2'd2 ? mtimecmp : 32'(gpio_o);
  assign bus.ram_data_o = mmio ? mmio_rd : mem[word];
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_sel[i]) mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      mtime       <= '0;
      mtimecmp    <= '0;
      gpio_o      <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      mtime <= mtime + 64'd1;
      if (cmp_wr) mtimecmp <= (mtimecmp & ~lane_mask) | (bus.ram_data_i & lane_mask);
      if (gpio_wr) gpio_o <= (gpio_o & ~lane_mask[GPIO_W-1:0]) | (bus.ram_data_i[GPIO_W-1:0] & lane_mask[GPIO_W-1:0]);
      timer_irq_o <= cmp_wr ? 1'b0 : (timer_irq_o | irq_hit);
    end
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed vectors for RAM, loader, timer/irq and gpio
module tb_data_ram_resp;
  logic       clk = 1'b0;
  logic       rst;
  logic       timer_irq_o;
  logic [7:0] gpio_o;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] d, m, first;
  logic        seen;
  data_ram_resp_if #(.DEPTH_LOG2(10)) bus ();
  data_ram_resp #(.DEPTH_LOG2(10), .GPIO_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .timer_irq_o(timer_irq_o), .gpio_o(gpio_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] q);
    bus.ram_addr_i = a;
    #1;
    q = bus.ram_data_o;
  endtask
  task automatic core_wr(input logic [11:0] a, input logic [3:0] s, input logic [31:0] v);
    bus.ram_we_i = 1'b1;
    bus.ram_addr_i = a;
    bus.ram_sel_i = s;
    bus.ram_data_i = v;
    tick;
    bus.ram_we_i = 1'b0;
    bus.ram_sel_i = 4'h0;
    bus.ram_data_i = '0;
  endtask
  task automatic ld_word(input logic [9:0] a, input logic [31:0] v);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = a;
    bus.ld_data_i = v;
    tick;
    bus.ld_valid_i = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.ram_we_i = 1'b0;
    bus.ram_sel_i = 4'h0;
    bus.ram_addr_i = '0;
    bus.ram_data_i = '0;
    bus.ld_valid_i = 1'b0;
    bus.ld_addr_i = '0;
    bus.ld_data_i = '0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_gpio", gpio_o, 8'h00);
    check("rst_irq", timer_irq_o, 1'b0);
    rd(12'hFF0, d); check("rst_mtime_lo", d, 32'd0);
    rd(12'hFF8, d); check("rst_mtimecmp", d, 32'd0);
    core_wr(12'h040, 4'hF, 32'hDEADBEEF);
    core_wr(12'h041, 4'b0010, 32'h0000_5500);
    rd(12'h040, d); check("lane_merge", d, 32'hDEAD55EF);
    core_wr(12'h040, 4'h0, 32'hFFFFFFFF);
    rd(12'h040, d); check("sel0_noop", d, 32'hDEAD55EF);
    bus.ram_we_i = 1'b1; bus.ram_sel_i = 4'hF; bus.ram_data_i = 32'h0;
    rd(12'h040, d); check("rd_during_wr_old", d, 32'hDEAD55EF);
    tick;
    bus.ram_we_i = 1'b0; bus.ram_sel_i = 4'h0;
    rd(12'h040, d); check("rd_after_wr_new", d, 32'h0);
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 10'd5; bus.ld_data_i = 32'h11223344;
    #1 check("ld_ready_idle", bus.ld_ready_o, 1'b1);
    tick;
    bus.ld_valid_i = 1'b0;
    rd(12'h014, d); check("ld_word5", d, 32'h11223344);
    ld_word(10'd6, 32'h0);
    ld_word(10'd7, 32'h0);
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 10'd6; bus.ld_data_i = 32'hAABBCCDD;
    bus.ram_we_i = 1'b1; bus.ram_addr_i = 12'h040; bus.ram_sel_i = 4'hF; bus.ram_data_i = 32'h12345678;
    #1 check("ld_ready_stall", bus.ld_ready_o, 1'b0);
    tick;
    bus.ram_we_i = 1'b0; bus.ram_sel_i = 4'h0;
    #1 check("ld_ready_after", bus.ld_ready_o, 1'b1);
    rd(12'h018, d); check("ld_not_yet", d, 32'h0);
    rd(12'h040, d); check("core_wr_prio", d, 32'h12345678);
    tick;
    bus.ld_valid_i = 1'b0;
    rd(12'h018, d); check("ld_landed", d, 32'hAABBCCDD);
    ld_word(10'd1023, 32'hFFFFFFFF);
    rd(12'hFFC, d); check("ld_alias_hidden", d, 32'h0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    rd(12'hFF0, d); check("mtime_after_rst", d, 32'd0);
    repeat (5) tick;
    rd(12'hFF0, d); check("mtime_lo_5", d, 32'd5);
    rd(12'hFF4, d); check("mtime_hi_0", d, 32'd0);
    force dut.mtime = 64'hFFFF_FFFF_FFFF_FFFF;
    rd(12'hFF0, d); check("forced_lo", d, 32'hFFFFFFFF);
    release dut.mtime;
    tick;
    rd(12'hFF0, d); check("wrap_lo", d, 32'h0);
    rd(12'hFF4, d); check("wrap_hi", d, 32'h0);
    core_wr(12'hFF8, 4'hF, 32'd20);
    rd(12'hFF8, d); check("cmp_rd", d, 32'd20);
    first = '0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      if (timer_irq_o) begin
        seen = 1'b1;
        rd(12'hFF0, first);
      end
    end
    check("irq_seen", seen, 1'b1);
    check("irq_rise_mtime", first, 32'd21);
    repeat (3) tick;
    check("irq_sticky", timer_irq_o, 1'b1);
    core_wr(12'hFF8, 4'b0001, 32'h0);
    check("irq_clr", timer_irq_o, 1'b0);
    rd(12'hFF8, d); check("cmp_zero", d, 32'h0);
    repeat (30) tick;
    check("irq_stays_clr", timer_irq_o, 1'b0);
    rd(12'hFF0, m);
    core_wr(12'hFF8, 4'hF, m + 32'd3);
    tick;
    tick;
    core_wr(12'hFF8, 4'b1000, 32'h0);
    check("irq_clr_wins", timer_irq_o, 1'b0);
    rd(12'hFF8, d); check("cmp_lane3_only", d, m + 32'd3);
    repeat (2) tick;
    check("irq_no_late_set", timer_irq_o, 1'b0);
    core_wr(12'hFFC, 4'b0001, 32'h0000_00A5);
    check("gpio_wr", gpio_o, 8'hA5);
    rd(12'hFFC, d); check("gpio_rd", d, 32'h0000_00A5);
    core_wr(12'hFFC, 4'b0010, 32'hFFFF_FF00);
    check("gpio_lane1_ign", gpio_o, 8'hA5);
    core_wr(12'hFF0, 4'hF, 32'h0);
    rd(12'hFF4, d); check("mtime_ro", d, 32'h0);
    rst = 1'b1;
    bus.ram_we_i = 1'b1; bus.ram_addr_i = 12'h040; bus.ram_sel_i = 4'hF; bus.ram_data_i = 32'h00000BAD;
    bus.ld_valid_i = 1'b1; bus.ld_addr_i = 10'd7; bus.ld_data_i = 32'h55;
    #1 check("rst_ld_ready_we", bus.ld_ready_o, 1'b0);
    tick;
    bus.ram_we_i = 1'b0; bus.ram_sel_i = 4'h0;
    #1 check("rst_ld_ready_idle", bus.ld_ready_o, 1'b1);
    tick;
    bus.ld_valid_i = 1'b0;
    rst = 1'b0;
    check("gpio_rst", gpio_o, 8'h00);
    rd(12'h040, d); check("ram_kept", d, 32'h12345678);
    rd(12'h01C, d); check("rst_ld_dropped", d, 32'h0);
    rd(12'h018, d); check("ram_kept_ld", d, 32'hAABBCCDD);
    rd(12'hFF8, d); check("cmp_rst", d, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
